// File: rtl/alu_sequencer.sv
// Sequences an 8-bit AND/OR/ADD/ADD-INV request through an external 4-bit ALU, low nibble then high nibble,
// with a carry-fix pass on the high nibble. Define ALU_SEQ_ZERO_FLAG_EN to add the rsp_zero output.
module alu_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic [1:0] req_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_op,
  input  logic [3:0] alu_out,
  input  logic       alu_carry,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic       rsp_carry,
`ifdef ALU_SEQ_ZERO_FLAG_EN
  output logic       rsp_zero,
`endif
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_HI   = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t     r_state;
  logic [3:0] r_a_hi;
  logic [3:0] r_b_hi;
  logic       r_arith;
  logic [7:0] r_res;
  logic       r_c_lo;
  logic       r_c_hi;
  logic [3:0] r_alu_a;
  logic [3:0] r_alu_b;
  logic [1:0] r_alu_op;
  logic       r_req_ready;
  logic       r_busy;
  logic       r_rsp_valid;
  logic       r_rsp_carry;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic       r_rsp_zero;
`endif

  logic       w_fix_carry;
  assign w_fix_carry = r_c_hi | alu_carry;

  // Sequencer FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a_hi      <= 4'd0;
      r_b_hi      <= 4'd0;
      r_arith     <= 1'b0;
      r_res       <= 8'd0;
      r_c_lo      <= 1'b0;
      r_c_hi      <= 1'b0;
      r_alu_a     <= 4'd0;
      r_alu_b     <= 4'd0;
      r_alu_op    <= 2'd0;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_carry <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
      r_rsp_zero  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_a_hi      <= req_a[7:4];
            r_b_hi      <= req_b[7:4];
            r_arith     <= req_op[1];
            r_alu_a     <= req_a[3:0];
            r_alu_b     <= req_b[3:0];
            r_alu_op    <= req_op;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_LO;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_LO: begin
          r_res[3:0] <= alu_out;
          r_c_lo     <= alu_carry;
          r_alu_a    <= r_a_hi;
          r_alu_b    <= r_b_hi;
          r_state    <= S_HI;
        end
        S_HI: begin
          r_res[7:4] <= alu_out;
          r_c_hi     <= alu_carry;
          // A low-nibble carry on an add op still has to be folded into the high nibble.
          if (r_arith && r_c_lo) begin
            r_alu_a  <= alu_out;
            r_alu_b  <= 4'b0001;
            r_alu_op <= 2'b10;
            r_state  <= S_FIX;
          end else begin
            r_alu_a     <= 4'd0;
            r_alu_b     <= 4'd0;
            r_alu_op    <= 2'd0;
            r_rsp_valid <= 1'b1;
            r_rsp_carry <= r_arith & alu_carry;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            r_rsp_zero  <= ({alu_out, r_res[3:0]} == 8'h00);
`endif
            r_state     <= S_DONE;
          end
        end
        S_FIX: begin
          r_res[7:4]  <= alu_out;
          r_c_hi      <= w_fix_carry;
          r_alu_a     <= 4'd0;
          r_alu_b     <= 4'd0;
          r_alu_op    <= 2'd0;
          r_rsp_valid <= 1'b1;
          r_rsp_carry <= r_arith & w_fix_carry;
`ifdef ALU_SEQ_ZERO_FLAG_EN
          r_rsp_zero  <= ({alu_out, r_res[3:0]} == 8'h00);
`endif
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (rsp_ready) begin
            r_res       <= 8'd0;
            r_c_lo      <= 1'b0;
            r_c_hi      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_carry <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            r_rsp_zero  <= 1'b0;
`endif
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_state <= S_DONE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_res       <= 8'd0;
          r_alu_a     <= 4'd0;
          r_alu_b     <= 4'd0;
          r_alu_op    <= 2'd0;
          r_rsp_valid <= 1'b0;
          r_rsp_carry <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
          r_rsp_zero  <= 1'b0;
`endif
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_op     = r_alu_op;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_res;
  assign rsp_carry  = r_rsp_carry;
  assign busy       = r_busy;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  assign rsp_zero   = r_rsp_zero;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: models the external 4-bit ALU and predicts each response
// from whole-byte arithmetic.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [1:0] req_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_op;
  logic [3:0] alu_out;
  logic       alu_carry;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_carry;
  logic       busy;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic       rsp_zero;
`endif

  int n_cmp = 0;
  int n_err = 0;

  alu_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry),
`ifdef ALU_SEQ_ZERO_FLAG_EN
    .rsp_zero(rsp_zero),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  // External 4-bit ALU; logic ops report carry=1 so a sequencer that fails to ignore it shows up.
  always_comb begin
    logic [4:0] sum;
    sum = 5'd0;
    case (alu_op)
      2'b00: begin alu_out = alu_a & alu_b; alu_carry = 1'b1; end
      2'b01: begin alu_out = alu_a | alu_b; alu_carry = 1'b1; end
      2'b10: begin sum = {1'b0, alu_a} + {1'b0, alu_b};  alu_out = sum[3:0]; alu_carry = sum[4]; end
      default: begin sum = {1'b0, alu_a} + {1'b0, ~alu_b}; alu_out = sum[3:0]; alu_carry = sum[4]; end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op, input int hold);
    logic [8:0] full;
    logic [7:0] bb;
    logic [7:0] exp_res;
    logic       exp_c;
    logic       exp_fix;
    int         exp_lat;
    int         k;
    int         t;
    logic       saw_fix;
    bb = op[0] ? ~b : b;
    full = {1'b0, a} + {1'b0, bb};
    case (op)
      2'b00:   begin exp_res = a & b; exp_c = 1'b0; end
      2'b01:   begin exp_res = a | b; exp_c = 1'b0; end
      default: begin exp_res = full[7:0]; exp_c = full[8]; end
    endcase
    exp_fix = op[1] && (({1'b0, a[3:0]} + {1'b0, bb[3:0]}) > 5'd15);
    exp_lat = exp_fix ? 4 : 3;
    rsp_ready = 1'b0;
    t = 0;
    while (!req_ready && t < 20) begin tick(); t++; end
    chk("req_ready_idle", req_ready, 1);
    req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
    tick();
    saw_fix = 1'b0;
    k = 1;
    while (!rsp_valid && k < 8) begin
      chk("busy_inflight", {busy, req_ready}, 2'b10);
      if (k == 1) chk("lo_drive", {alu_a, alu_b, alu_op}, {a[3:0], b[3:0], op});
      if (k == 2) chk("hi_drive", {alu_a, alu_b, alu_op}, {a[7:4], b[7:4], op});
      if (k == 3) saw_fix = (alu_b == 4'b0001) && (alu_op == 2'b10) && (alu_a == full[7:4] - 4'd1);
      req_valid = 1'($urandom); req_a = 8'($urandom); req_b = 8'($urandom); req_op = 2'($urandom);
      tick();
      k++;
    end
    req_valid = 1'b0;
    chk("latency", k, exp_lat);
    chk("fix_visit", saw_fix, exp_fix);
    chk("result", rsp_result, exp_res);
    chk("carry", rsp_carry, exp_c);
    chk("done_alu_zero", {alu_a, alu_b, alu_op, req_ready, busy}, 12'h001);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    chk("zero_flag", rsp_zero, exp_res == 8'h00);
`endif
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_stable", {rsp_valid, rsp_result, rsp_carry, req_ready}, {1'b1, exp_res, exp_c, 1'b0});
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("back_idle", {rsp_valid, req_ready, busy}, 3'b010);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    chk("zero_idle", rsp_zero, 1'b0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_a = 8'd0; req_b = 8'd0; req_op = 2'd0; rsp_ready = 1'b0;
    tick(); tick();
    chk("reset_outputs", {rsp_valid, rsp_result, rsp_carry, busy, alu_a, alu_b, alu_op}, 22'd0);
    rst = 1'b0;
    tick();
    chk("reset_ready", req_ready, 1'b1);

    run_txn(8'hF0, 8'h3C, 2'b00, 0);
    run_txn(8'h0F, 8'h01, 2'b10, 0);
    run_txn(8'hFF, 8'h01, 2'b10, 1);
    run_txn(8'h05, 8'h03, 2'b11, 0);
    run_txn(8'h12, 8'h34, 2'b10, 5);
    run_txn(8'h0F, 8'hF0, 2'b00, 0);
    run_txn(8'h01, 8'h00, 2'b01, 2);

    // Reset pulsed while the high nibble is in flight.
    req_a = 8'h77; req_b = 8'h99; req_op = 2'b10; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    chk("in_hi", {alu_a, alu_b}, 8'h79);
    #2 rst = 1'b1;
    #1;
    chk("rst_async", {rsp_valid, rsp_result, rsp_carry, busy, alu_a, alu_b, alu_op}, 22'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_quiet", {rsp_valid, busy, req_ready}, 3'b001);
    end
    run_txn(8'h12, 8'h34, 2'b10, 0);

    for (int i = 0; i < 40; i++)
      run_txn(8'($urandom), 8'($urandom), 2'($urandom), int'($urandom_range(0, 3)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
